// File: rtl/nn_pkg.sv
// Shared neural-network datapath helpers.
// Accumulator sizing and saturation rails for MAC and activation.
package nn_pkg;

  // Widest accumulator any helper below is asked to describe.
  localparam int SAT_MAXW = 128;

  function automatic int acc_width(int dw, int ie);
    return 2 * dw + ie;
  endfunction

  // Most positive w-bit two's complement value, zero-padded.
  function automatic logic [SAT_MAXW-1:0] sat_pos(int w);
    logic [SAT_MAXW-1:0] r;
    r = '0;
    for (int i = 0; i < SAT_MAXW; i++) begin
      if (i < w - 1) r[i] = 1'b1;
    end
    return r;
  endfunction

  // Most negative w-bit two's complement value, zero-padded.
  function automatic logic [SAT_MAXW-1:0] sat_neg(int w);
    logic [SAT_MAXW-1:0] r;
    r = '0;
    for (int i = 0; i < SAT_MAXW; i++) begin
      if (i == w - 1) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/neuron_mac_sat_add.sv
// Combinational W-bit signed saturating adder.
// ovf_o flags that the result was clamped to a rail.
module sat_add
  import nn_pkg::*;
#(
  parameter int W = 42
) (
  input  logic signed [W-1:0] a_i,
  input  logic signed [W-1:0] b_i,
  output logic signed [W-1:0] sum_o,
  output logic                ovf_o
);

  localparam logic [SAT_MAXW-1:0] POS_W = sat_pos(W);
  localparam logic [SAT_MAXW-1:0] NEG_W = sat_neg(W);
  localparam logic [W-1:0] POS = POS_W[W-1:0];
  localparam logic [W-1:0] NEG = NEG_W[W-1:0];

  logic [W:0] wide;

  // One extra bit exposes overflow as a mismatch of the top two bits.
  always_comb begin
    wide  = {a_i[W-1], a_i} + {b_i[W-1], b_i};
    ovf_o = wide[W] ^ wide[W-1];
    sum_o = wide[W-1:0];
    if (ovf_o) begin
      sum_o = wide[W] ? NEG : POS;
    end
  end

endmodule

// File: rtl/neuron_mac.sv
// Neuron multiply-accumulate front end.
// Two-stage pipe: product register, then saturating accumulate.
module neuron_mac
  import nn_pkg::*;
#(
  parameter int dataWidth      = 16,
  parameter int weightIntWidth = 4,
  parameter int IntWidthExtend = 10,
  parameter int numInputs      = 784,
  localparam int ACCW = acc_width(dataWidth, IntWidthExtend),
  localparam int CNTW = (numInputs > 1) ? $clog2(numInputs) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic signed [dataWidth-1:0]   in_data,
  input  logic signed [dataWidth-1:0]   in_weight,
  input  logic signed [2*dataWidth-1:0] bias,
  output logic                          out_valid,
  output logic signed [ACCW-1:0]        out_sum,
  output logic                          busy
);

  localparam int PW = 2 * dataWidth;
  localparam logic [CNTW-1:0] LAST = CNTW'(numInputs - 1);

  localparam logic [SAT_MAXW-1:0] POS_W = sat_pos(ACCW);
  localparam logic [SAT_MAXW-1:0] NEG_W = sat_neg(ACCW);

  // weightIntWidth only fixes the meaning of out_sum's binary point.
  if (numInputs < 1) begin : g_bad_n
    $error("neuron_mac: numInputs must be at least 1");
  end
  if (weightIntWidth < 0 || weightIntWidth > dataWidth) begin : g_bad_w
    $error("neuron_mac: weightIntWidth out of range");
  end

  logic [CNTW-1:0] in_cnt_q, in_cnt_d;
  logic            is_first, is_last;

  logic                 v1_q;
  logic                 first1_q;
  logic                 last1_q;
  logic signed [PW-1:0] p1_q;
  logic signed [PW-1:0] b1_q;
  logic signed [PW-1:0] prod;

  logic signed [ACCW-1:0] acc_q;
  logic                   out_valid_q;
  logic signed [ACCW-1:0] p1_ext;
  logic signed [ACCW-1:0] b1_ext;
  logic signed [ACCW-1:0] op_a;
  logic signed [ACCW-1:0] sat_sum;
  logic                   sat_ovf;

  assign is_first = (in_cnt_q == '0);
  assign is_last  = (in_cnt_q == LAST);
  assign prod     = in_data * in_weight;

  // Pair counter: advance per accepted pair, wrap after the last one.
  always_comb begin
    in_cnt_d = in_cnt_q;
    if (in_valid) begin
      in_cnt_d = is_last ? '0 : in_cnt_q + 1'b1;
    end
  end

  // Counter register; reset abandons any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_cnt_q <= '0;
    end else begin
      in_cnt_q <= in_cnt_d;
    end
  end

  // Stage 1: register product, frame markers and first-pair bias.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q     <= 1'b0;
      first1_q <= 1'b0;
      last1_q  <= 1'b0;
    end else begin
      v1_q <= in_valid;
      if (in_valid) begin
        p1_q     <= prod;
        first1_q <= is_first;
        last1_q  <= is_last;
        if (is_first) begin
          b1_q <= bias;
        end
      end
    end
  end

  assign p1_ext = ACCW'(p1_q);
  assign b1_ext = ACCW'(b1_q);
  assign op_a   = first1_q ? b1_ext : acc_q;

  sat_add #(
    .W(ACCW)
  ) u_sat (
    .a_i  (op_a),
    .b_i  (p1_ext),
    .sum_o(sat_sum),
    .ovf_o(sat_ovf)
  );

  // Stage 2: saturating accumulate; pulse once the last term lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= v1_q & last1_q;
      if (v1_q) begin
        acc_q <= sat_sum;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = acc_q;
  assign busy      = (in_cnt_q != '0);

  a_sat_rail : assert property (
    @(posedge clk) disable iff (rst)
    (v1_q && sat_ovf) |->
      (sat_sum == POS_W[ACCW-1:0] || sat_sum == NEG_W[ACCW-1:0])
  );

endmodule
